// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the MIPS datapath and the data-memory responder.
interface dmem_responder_if;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        errM;

  modport master (
    output memreadM, memwriteM, aluoutM, writedataM,
    input  readdataM, stallM, errM
  );

  modport slave (
    input  memreadM, memwriteM, aluoutM, writedataM,
    output readdataM, stallM, errM
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MIPS memory stage: holds stallM for LATENCY cycles per
// access, then completes the load/store and reports access errors in the DONE cycle.
module dmem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [31:0]            addr_q;
  logic [31:0]            data_q;
  logic                   write_q;
  logic                   dual_q;
  logic [31:0]            readdata_q;
  logic                   err_q;
  logic [31:0]            mem_q [DEPTH];

  logic                   req;
  logic                   useLive;
  logic [31:0]            effAddr;
  logic [31:0]            effData;
  logic                   effWrite;
  logic                   effDual;
  logic                   badAddr;
  logic [ADDR_BITS-1:0]   index;
  logic                   goDone;

  // With LATENCY==1 the access completes on the accepting edge, so the live inputs
  // stand in for the not-yet-latched copy.
  always_comb begin
    req      = bus.memreadM | bus.memwriteM;
    useLive  = (state_q == IDLE);
    effAddr  = useLive ? bus.aluoutM    : addr_q;
    effData  = useLive ? bus.writedataM : data_q;
    effWrite = useLive ? bus.memwriteM  : write_q;
    effDual  = useLive ? (bus.memreadM & bus.memwriteM) : dual_q;
    badAddr  = (effAddr[1:0] != 2'b00) || ((effAddr >> (ADDR_BITS + 2)) != 32'd0);
    index    = effAddr[ADDR_BITS+1:2];
    goDone   = ((state_q == IDLE) && req && (LATENCY == 1)) ||
               ((state_q == BUSY) && (cnt_q == 4'd1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      write_q    <= 1'b0;
      dual_q     <= 1'b0;
      readdata_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= bus.aluoutM;
            data_q  <= bus.writedataM;
            write_q <= bus.memwriteM;
            dual_q  <= bus.memreadM & bus.memwriteM;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY > 1) ? BUSY : DONE;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (goDone) begin
        err_q <= badAddr | effDual;
        if (!effWrite) readdata_q <= badAddr ? 32'd0 : mem_q[index];
      end
    end
  end

  // The array has no reset; a store aborted by reset never reaches it.
  always_ff @(posedge clk) begin
    if (reset && goDone && effWrite && !badAddr) mem_q[index] <= effData;
  end

  assign bus.stallM    = reset & (((state_q == IDLE) & req) | (state_q == BUSY));
  assign bus.readdataM = readdata_q;
  assign bus.errM      = err_q;

endmodule
